// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller register bank.
package int_ctrl_pkg;

    // Width of the CP0 HWInt bus; unused upper sources read as zero.
    localparam int HWINT_W = 6;

    // Word offsets of the MMIO registers on the bridge.
    typedef enum logic [1:0] {
        INTC_PEND  = 2'd0,
        INTC_MASK  = 2'd1,
        INTC_MODE  = 2'd2,
        INTC_CLAIM = 2'd3
    } intc_reg_e;

    // CLAIM read layout: {valid, id[2:0]} in the low nibble.
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } claim_t;

endpackage

// File: rtl/int_prio_enc.sv
// Priority encoder: reports the highest set index of req_i and whether any bit is set.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int NSRC = 6
) (
    input  logic [NSRC-1:0] req_i,
    output logic            valid_o,
    output logic [2:0]      id_o
);

    // Scan upwards so the last (highest) set index wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        valid_o = 1'b0;
        id_o    = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises sources, captures them as level or edge,
// masks them onto the CP0 HWInt bus and exposes PEND/MASK/MODE/CLAIM over MMIO.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NSRC = 6,
    parameter int SYNC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC-1:0]    src,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [HWINT_W-1:0] HWInt,
    output logic               irq
);

    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] src_dly_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] mode_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] claim_clr;
    logic [NSRC-1:0] mode_chg;
    logic [NSRC-1:0] masked;
    logic            wr_pend, wr_mask, wr_mode, wr_claim;
    claim_t          claim;

    // Only the low NSRC bits (and the CLAIM id) of the write bus carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign wr_pend  = we && (addr == INTC_PEND);
    assign wr_mask  = we && (addr == INTC_MASK);
    assign wr_mode  = we && (addr == INTC_MODE);
    assign wr_claim = we && (addr == INTC_CLAIM);

    generate
        if (SYNC != 0) begin : g_sync
            logic [NSRC-1:0] sync1_q, sync2_q;

            // Two-flop synchroniser for sources driven from other clock domains.
            always_ff @(posedge clk or posedge reset) begin
                // NOTE: flop state uses non-blocking assignment so each stage samples the pre-edge value of the previous one.
                if (reset) begin
                    sync1_q <= '0;
                    sync2_q <= '0;
                end else begin
                    sync1_q <= src;
                    sync2_q <= sync1_q;
                end
            end

            assign src_s = sync2_q;
        end else begin : g_nosync
            assign src_s = src;
        end
    endgenerate

    // Edge detect, clear strobes and mode-change strobes for this cycle.
    always_comb begin
        rise      = src_s & ~src_dly_q;
        w1c       = wr_pend ? wdata[NSRC-1:0] : '0;
        mode_chg  = wr_mode ? (wdata[NSRC-1:0] ^ mode_q) : '0;
        claim_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (wr_claim && (wdata[2:0] == 3'(i))) begin
                claim_clr[i] = 1'b1;
            end
        end
    end

    // Pending next state: mode change clears, level follows the line, edge sets over clears.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mode_chg[i]) begin
                pend_d[i] = 1'b0;
            end else if (!mode_q[i]) begin
                pend_d[i] = src_s[i];
            end else if (rise[i]) begin
                pend_d[i] = 1'b1;
            end else if (w1c[i] || claim_clr[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // Delayed source tracks src_s every cycle, so a MODE write never sees a stale edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_dly_q <= '0;
            pend_q    <= '0;
        end else begin
            src_dly_q <= src_s;
            pend_q    <= pend_d;
        end
    end

    // MASK and MODE configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            mode_q <= '0;
        end else begin
            if (wr_mask) mask_q <= wdata[NSRC-1:0];
            if (wr_mode) mode_q <= wdata[NSRC-1:0];
        end
    end

    assign masked = pend_q & mask_q;

    int_prio_enc #(
        .NSRC (NSRC)
    ) u_prio (
        .req_i   (masked),
        .valid_o (claim.valid),
        .id_o    (claim.id)
    );

    // HWInt is driven only from flops, zero-extended to the CP0 bus width.
    always_comb begin
        HWInt = '0;
        for (int i = 0; i < NSRC; i++) begin
            HWInt[i] = masked[i];
        end
    end

    assign irq = |masked;

    // Read mux; reads have no side effects.
    always_comb begin
        rdata = '0;
        case (intc_reg_e'(addr))
            INTC_PEND:  rdata[NSRC-1:0] = pend_q;
            INTC_MASK:  rdata[NSRC-1:0] = mask_q;
            INTC_MODE:  rdata[NSRC-1:0] = mode_q;
            INTC_CLAIM: rdata[3:0]      = claim;
            default:    rdata           = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl (NSRC=6, SYNC=1): vector table plus multi-cycle sequences.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  src = '0;
    logic        we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [5:0]  HWInt;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    int_ctrl #(
        .NSRC (6),
        .SYNC (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .HWInt (HWInt),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  src;
        logic [1:0]  raddr;
        logic [31:0] exp_rdata;
        logic [5:0]  exp_hw;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Level-mode walk through sync latency, then priority and masking.
        vecs[0]  = '{1'b1, 2'd1, 32'h3F, 6'h04, 2'd1, 32'h3F, 6'h00};
        vecs[1]  = '{1'b0, 2'd0, 32'h00, 6'h04, 2'd0, 32'h00, 6'h00};
        vecs[2]  = '{1'b0, 2'd0, 32'h00, 6'h04, 2'd0, 32'h04, 6'h04};
        vecs[3]  = '{1'b0, 2'd0, 32'h00, 6'h04, 2'd3, 32'h0A, 6'h04};
        vecs[4]  = '{1'b0, 2'd0, 32'h00, 6'h00, 2'd0, 32'h04, 6'h04};
        vecs[5]  = '{1'b0, 2'd0, 32'h00, 6'h00, 2'd0, 32'h04, 6'h04};
        vecs[6]  = '{1'b0, 2'd0, 32'h00, 6'h00, 2'd0, 32'h00, 6'h00};
        vecs[7]  = '{1'b0, 2'd0, 32'h00, 6'h24, 2'd0, 32'h00, 6'h00};
        vecs[8]  = '{1'b0, 2'd0, 32'h00, 6'h24, 2'd0, 32'h00, 6'h00};
        vecs[9]  = '{1'b0, 2'd0, 32'h00, 6'h24, 2'd3, 32'h0D, 6'h24};
        vecs[10] = '{1'b1, 2'd1, 32'h1F, 6'h24, 2'd3, 32'h0A, 6'h04};
        vecs[11] = '{1'b1, 2'd1, 32'h00, 6'h24, 2'd3, 32'h00, 6'h00};
        vecs[12] = '{1'b0, 2'd0, 32'h00, 6'h24, 2'd0, 32'h24, 6'h00};
        vecs[13] = '{1'b1, 2'd0, 32'h24, 6'h24, 2'd0, 32'h24, 6'h00};
        vecs[14] = '{1'b0, 2'd0, 32'h00, 6'h24, 2'd2, 32'h00, 6'h00};

        // Reset state.
        step(3);
        reset = 1'b0;
        #1;
        check("reset HWInt", 32'(HWInt), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        rd("reset PEND", INTC_PEND, 32'h0);
        rd("reset MASK", INTC_MASK, 32'h0);
        rd("reset MODE", INTC_MODE, 32'h0);
        rd("reset CLAIM", INTC_CLAIM, 32'h0);

        for (int i = 0; i < 15; i++) begin
            we    = vecs[i].we;
            addr  = vecs[i].we ? vecs[i].waddr : vecs[i].raddr;
            wdata = vecs[i].wdata;
            src   = vecs[i].src;
            step();
            we    = 1'b0;
            wdata = '0;
            rd($sformatf("vec%0d rdata", i), vecs[i].raddr, vecs[i].exp_rdata);
            check($sformatf("vec%0d HWInt", i), 32'(HWInt), 32'(vecs[i].exp_hw));
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(|vecs[i].exp_hw));
        end

        // Edge capture on src[0], CLAIM ignore/clear behaviour.
        src = '0;
        wr(INTC_MODE, 32'h01);
        wr(INTC_MASK, 32'h01);
        step(3);
        rd("edge idle PEND", INTC_PEND, 32'h0);
        src = 6'h01;
        step();
        src = 6'h00;
        step(4);
        rd("edge pulse PEND", INTC_PEND, 32'h01);
        check("edge pulse HWInt", 32'(HWInt), 32'h01);
        rd("edge pulse CLAIM", INTC_CLAIM, 32'h08);
        wr(INTC_CLAIM, 32'h7);
        rd("claim id7 ignored", INTC_PEND, 32'h01);
        wr(INTC_CLAIM, 32'h3);
        rd("claim other id keeps", INTC_PEND, 32'h01);
        wr(INTC_CLAIM, 32'h0);
        rd("claim clears PEND", INTC_PEND, 32'h0);
        check("claim clears HWInt", 32'(HWInt), 32'h0);

        // Rise and W1C in the same cycle: set wins.
        wr(INTC_MODE, 32'h09);
        wr(INTC_MASK, 32'h3F);
        src = 6'h08;
        step(2);
        wr(INTC_PEND, 32'h08);
        rd("set beats W1C", INTC_PEND, 32'h08);
        wr(INTC_PEND, 32'h08);
        rd("W1C clears edge", INTC_PEND, 32'h00);
        src = 6'h0C;
        step(3);
        rd("level bit2 pending", INTC_PEND, 32'h04);
        wr(INTC_PEND, 32'h04);
        rd("W1C level no effect", INTC_PEND, 32'h04);

        // Mode change with the line held high must not fire.
        src = 6'h0E;
        step(3);
        rd("level bit1 pending", INTC_PEND, 32'h06);
        wr(INTC_MODE, 32'h0B);
        rd("mode change clears", INTC_PEND, 32'h04);
        step(3);
        rd("no spurious edge", INTC_PEND, 32'h04);
        src = 6'h0C;
        step(4);
        src = 6'h0E;
        step(2);
        rd("rise in sync pipe", INTC_PEND, 32'h04);
        step();
        rd("rise after mode change", INTC_PEND, 32'h06);
        check("rise HWInt", 32'(HWInt), 32'h06);

        // All pending, then asynchronous reset between clock edges.
        wr(INTC_MODE, 32'h00);
        src = 6'h3F;
        step(4);
        rd("all pending", INTC_PEND, 32'h3F);
        rd("all pending CLAIM", INTC_CLAIM, 32'h0D);
        #2;
        reset = 1'b1;
        #1;
        check("async reset HWInt", 32'(HWInt), 32'h0);
        check("async reset irq", 32'(irq), 32'h0);
        rd("async reset PEND", INTC_PEND, 32'h0);
        rd("async reset MASK", INTC_MASK, 32'h0);
        step();
        reset = 1'b0;
        step(4);
        rd("post reset level PEND", INTC_PEND, 32'h3F);
        check("post reset HWInt masked", 32'(HWInt), 32'h0);
        wr(INTC_MODE, 32'h3F);
        wr(INTC_MASK, 32'h3F);
        step(3);
        rd("edge mode high line quiet", INTC_PEND, 32'h0);
        check("edge mode high HWInt", 32'(HWInt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
